// File: rtl/fifo_width_downsizer.sv
// fifo_width_downsizer
// Splits each DATA_WIDTH-bit word taken from an upstream FIFO into
// RATIO = DATA_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream, at full
// throughput. A new word is accepted in the same cycle the previous word's
// last beat is consumed. Byte order is chosen per word.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid_s    upstream word valid (FIFO o_valid_m)
//   i_datain     upstream word (FIFO o_dataout)
//   o_ready_s    upstream accept (FIFO i_ready_m), combinational
//   i_msb_first  byte order for the word being accepted
//   o_valid_m    output beat valid
//   i_ready_m    downstream ready
//   o_dataout    output beat
//   o_last       final beat of the current word
//   o_beat_idx   beat index within the word, 0..RATIO-1
module fifo_width_downsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH / OUT_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_ready_s,
    input  logic                  i_msb_first,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [OUT_WIDTH-1:0]  o_dataout,
    output logic                  o_last,
    output logic [CNT_W-1:0]      o_beat_idx
);

    localparam int unsigned RATIO = 32'(DATA_WIDTH / OUT_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    // Reject widths that do not split into at least two whole beats
    generate
        if ((DATA_WIDTH % OUT_WIDTH != 0) || (DATA_WIDTH / OUT_WIDTH < 2)) begin : g_bad_ratio
            $error("fifo_width_downsizer: DATA_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q,  hold_d;
    logic                    order_q, order_d;
    logic [CNT_W-1:0]        idx_q,   idx_d;
    logic [OUT_WIDTH-1:0]    dout_q,  dout_d;
    logic                    last_q,  last_d;

    logic                    accept;
    logic                    fire;
    logic [CNT_W-1:0]        sel;
    logic [OUT_WIDTH-1:0]    beat;

    // Upstream may load when empty, or when the last beat leaves this cycle
    assign o_ready_s = i_rst_n & ((state_q == IDLE) | (i_ready_m & last_q));
    assign accept    = i_valid_s & o_ready_s;
    assign fire      = (state_q == SEND) & i_ready_m;

    // Next-state and next-output logic; a load wins over beat advance
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        order_d = order_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        last_d  = 1'b0;
        sel     = '0;
        beat    = '0;

        if (accept) begin
            hold_d  = i_datain;
            order_d = i_msb_first;
            idx_d   = '0;
            state_d = SEND;
        end else if (fire) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end

        // MSB-first walks the slices from the top down
        sel = order_d ? (LAST_IDX - idx_d) : idx_d;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (sel == CNT_W'(k)) begin
                beat = hold_d[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end

        // Output beat is frozen while idle
        if (state_d == SEND) begin
            dout_d = beat;
            last_d = (idx_d == LAST_IDX);
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            order_q <= 1'b0;
            idx_q   <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            order_q <= order_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end

    assign o_valid_m  = (state_q == SEND);
    assign o_dataout  = dout_q;
    assign o_last     = last_q;
    assign o_beat_idx = idx_q;

endmodule

// File: tb/tb_fifo_width_downsizer.sv
// Testbench for fifo_width_downsizer (DATA_WIDTH=32, OUT_WIDTH=8).
// An upstream word queue stands in for the FIFO; accepted words are expanded
// into expected beats on a scoreboard queue and compared as beats leave.
module tb_fifo_width_downsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_s;
    logic [31:0] datain;
    logic        ready_s;
    logic        msb_first;
    logic        valid_m;
    logic        ready_m;
    logic [7:0]  dout;
    logic        last;
    logic [1:0]  beat_idx;

    typedef struct {
        logic [31:0] d;
        logic        msb;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    word_t src_q[$];
    beat_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    logic noise  = 1'b0;

    always #5 clk = ~clk;

    fifo_width_downsizer #(
        .DATA_WIDTH(32),
        .OUT_WIDTH (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid_s  (valid_s),
        .i_datain   (datain),
        .o_ready_s  (ready_s),
        .i_msb_first(msb_first),
        .o_valid_m  (valid_m),
        .i_ready_m  (ready_m),
        .o_dataout  (dout),
        .o_last     (last),
        .o_beat_idx (beat_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the head of the upstream queue; scramble order/data when empty
    task automatic drive_src();
        if (src_q.size() > 0) begin
            valid_s   = 1'b1;
            datain    = src_q[0].d;
            msb_first = src_q[0].msb;
        end else begin
            valid_s   = 1'b0;
            datain    = $urandom;
            noise     = ~noise;
            msb_first = noise;
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic msb);
        word_t w;
        w.d   = d;
        w.msb = msb;
        src_q.push_back(w);
        drive_src();
    endtask

    task automatic push_beats(input word_t w);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            int s;
            s      = w.msb ? (3 - k) : k;
            b.d    = w.d[s*8 +: 8];
            b.idx  = 2'(k);
            b.last = (k == 3);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: compare at the falling edge, update model, re-drive
    task automatic tick();
        word_t w;
        @(negedge clk);
        chk("valid_m", {31'b0, valid_m}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("dataout",  {24'b0, dout},     {24'b0, exp_q[0].d});
            chk("beat_idx", {30'b0, beat_idx}, {30'b0, exp_q[0].idx});
            chk("last",     {31'b0, last},     {31'b0, exp_q[0].last});
            chk("ready_s",  {31'b0, ready_s},  {31'b0, ready_m & exp_q[0].last});
            if (ready_m) void'(exp_q.pop_front());
        end else begin
            chk("ready_s_idle", {31'b0, ready_s}, {31'b0, rst_n});
        end
        if (valid_s && ready_s && src_q.size() > 0) begin
            w = src_q.pop_front();
            push_beats(w);
        end
        @(posedge clk);
        #1;
        drive_src();
    endtask

    initial begin
        rst_n   = 1'b0;
        ready_m = 1'b1;
        drive_src();
        #2;
        chk("rst_valid", {31'b0, valid_m},  32'h0);
        chk("rst_last",  {31'b0, last},     32'h0);
        chk("rst_dout",  {24'b0, dout},     32'h0);
        chk("rst_idx",   {30'b0, beat_idx}, 32'h0);
        chk("rst_ready", {31'b0, ready_s},  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'b0, ready_s}, 32'h1);

        // LSB-first single word
        push_word(32'hA1B2C3D4, 1'b0);
        repeat (6) tick();

        // MSB-first single word, order input toggles while the word is held
        push_word(32'hA1B2C3D4, 1'b1);
        repeat (6) tick();

        // Back-to-back words, continuous stream
        push_word(32'h11223344, 1'b0);
        push_word(32'h55667788, 1'b0);
        repeat (10) tick();

        // Backpressure on beat index 1
        push_word(32'hA1B2C3D4, 1'b0);
        tick();
        tick();
        ready_m = 1'b0;
        repeat (3) tick();
        ready_m = 1'b1;
        repeat (4) tick();

        // Reset while beat 1 of a word is presented
        push_word(32'hDEADBEEF, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_valid", {31'b0, valid_m},  32'h0);
        chk("midrst_last",  {31'b0, last},     32'h0);
        chk("midrst_dout",  {24'b0, dout},     32'h0);
        chk("midrst_idx",   {30'b0, beat_idx}, 32'h0);
        chk("midrst_ready", {31'b0, ready_s},  32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Upstream gap, then a new word from idle
        push_word(32'h12345678, 1'b0);
        repeat (7) tick();
        push_word(32'hCAFEF00D, 1'b0);
        repeat (6) tick();

        chk("drain_exp", exp_q.size(), 32'h0);
        chk("drain_src", src_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
